// File: rtl/input_conditioner_pkg.sv
// Shared stopwatch package: debounce defaults, channel indices and common types
// for the push-button and switch input conditioner.
package input_conditioner_pkg;

    // Default clk cycles between debounce samples (1 ms at 100 MHz).
    localparam int unsigned SAMPLE_DIV_DEFAULT   = 100000;
    // Default consecutive differing samples needed to accept a new level.
    localparam int unsigned STABLE_COUNT_DEFAULT = 4;

    // Legal range of the stable count; the counter width covers the maximum.
    localparam int unsigned STABLE_COUNT_MIN = 2;
    localparam int unsigned STABLE_COUNT_MAX = 15;
    localparam int unsigned STABLE_W         = 4;

    // Channel ordering inside the raw / debounced vectors.
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_RST   = 0;
    localparam int unsigned CH_PAUSE = 1;
    localparam int unsigned CH_ADJ   = 2;
    localparam int unsigned CH_SEL   = 3;

    // Per-channel conditioned result.
    typedef struct packed {
        logic level;
        logic rise;
    } db_out_t;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned count_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_conditioner_db_channel.sv
// One debounce channel: 2-flop synchronizer, consecutive-sample stable counter,
// debounced level register and a one-clk rising-edge pulse.
module db_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise
);

    localparam logic [STABLE_W-1:0] LastCount = STABLE_W'(STABLE_COUNT - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [STABLE_W-1:0] cnt_q,   cnt_d;
    logic                level_q, level_d;
    logic                rose_q,  rose_d;
    logic                rise_q,  rise_d;

    // Next-state: synchronize, then count differing samples on each tick.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;

        if (tick) begin
            if (sync2_q != level_q) begin
                if (cnt_q == LastCount) begin
                    // This sample completes the run: accept the new level.
                    level_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                // A sample matching the current level breaks the run.
                cnt_d = '0;
            end
        end

        // rose marks the first cycle at the new high level; rise follows it by one clk.
        rose_d = level_d & ~level_q;
        rise_d = rose_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rose_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rose_q  <= rose_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Stopwatch input conditioner: shared sample prescaler, four debounce
// channels, clear pulse, pause toggle and debounced switch levels.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = SAMPLE_DIV_DEFAULT,
    parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_button,
    input  logic pause_button,
    input  logic adj_switch,
    input  logic sel_switch,
    output logic clear,
    output logic paused,
    output logic adj,
    output logic sel,
    output logic sample_tick
);

    localparam int unsigned            CntW    = count_width(SAMPLE_DIV);
    localparam logic [CntW-1:0]        CntLast = CntW'(SAMPLE_DIV - 1);

    // Elaboration-time parameter sanity checks.
    if (SAMPLE_DIV < 2) begin : g_bad_div
        $error("input_conditioner: SAMPLE_DIV must be at least 2");
    end
    if (STABLE_COUNT < STABLE_COUNT_MIN || STABLE_COUNT > STABLE_COUNT_MAX) begin : g_bad_cnt
        $error("input_conditioner: STABLE_COUNT must be within 2..15");
    end

    logic [CntW-1:0]   div_q, div_d;
    logic              tick;
    logic              paused_q, paused_d;
    logic [NUM_CH-1:0] raw_vec;
    db_out_t           ch_out [NUM_CH];

    assign raw_vec[CH_RST]   = rst_button;
    assign raw_vec[CH_PAUSE] = pause_button;
    assign raw_vec[CH_ADJ]   = adj_switch;
    assign raw_vec[CH_SEL]   = sel_switch;

    // Prescaler next-state: count 0..SAMPLE_DIV-1, tick on the last value.
    always_comb begin
        tick  = (div_q == CntLast);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Pause toggle next-state; a held rst_button forces and holds it cleared.
    always_comb begin
        paused_d = paused_q;
        if (ch_out[CH_RST].level) begin
            paused_d = 1'b0;
        end else if (ch_out[CH_PAUSE].rise) begin
            paused_d = ~paused_q;
        end
    end

    // Prescaler and pause state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            paused_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            paused_q <= paused_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        db_channel #(
            .STABLE_COUNT (STABLE_COUNT)
        ) u_db_channel (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_vec[i]),
            .tick  (tick),
            .level (ch_out[i].level),
            .rise  (ch_out[i].rise)
        );
    end

    // Switch channels only use their levels; the pause channel only its pulse.
    logic unused_ch;
    assign unused_ch = ch_out[CH_ADJ].rise ^ ch_out[CH_SEL].rise ^ ch_out[CH_PAUSE].level;

    assign clear       = ch_out[CH_RST].rise;
    assign paused      = paused_q;
    assign adj         = ch_out[CH_ADJ].level;
    assign sel         = ch_out[CH_SEL].level;
    assign sample_tick = tick;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000, clk cycles per debounce sample tick (>=2).
REQ-002 Parameter STABLE_COUNT, default 4, consecutive differing samples required to accept a new level (2..15).
REQ-003 clk  input  1  master clock, 100 MHz; the single clock of the block.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rst_button  input  1  raw asynchronous reset push-button.
REQ-006 pause_button  input  1  raw asynchronous pause push-button.
REQ-007 adj_switch  input  1  raw asynchronous adjust slide switch.
REQ-008 sel_switch  input  1  raw asynchronous select slide switch.
REQ-009 clear  output  1  one-clk pulse on each debounced rst_button rising edge.
REQ-010 paused  output  1  pause state level, toggled by each debounced pause_button press.
REQ-011 adj  output  1  debounced adj_switch level.
REQ-012 sel  output  1  debounced sel_switch level.
REQ-013 sample_tick  output  1  one-clk strobe marking each debounce sample instant.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 A prescaler SHALL count 0..SAMPLE_DIV-1 and wrap; sample_tick SHALL be high exactly in the cycle the count equals SAMPLE_DIV-1.
REQ-016 Per channel, on each sample_tick: synced value equal to debounced level -> stable counter cleared; otherwise counter incremented.
REQ-017 Debounced level SHALL take the synced value, and the counter SHALL clear, on the STABLE_COUNT-th consecutive differing sample.
REQ-018 Any sample equal to the debounced level SHALL restart the count (glitches shorter than STABLE_COUNT samples are rejected).
REQ-019 Per channel, a rise pulse SHALL assert for exactly one clk in the cycle after the debounced level goes 0->1; no pulse on 1->0.
REQ-020 clear SHALL be the rst_button channel rise pulse.
REQ-021 paused SHALL toggle in the cycle the pause_button rise pulse is high.
REQ-022 paused SHALL be forced to 0 whenever the rst_button debounced level is 1; this overrides a simultaneous pause pulse.
REQ-023 adj and sel SHALL equal their channels' debounced levels, no additional latency.
REQ-024 Latency, raw edge to debounced level: 2 clk (sync) plus STABLE_COUNT sample ticks; rise pulse one clk later.
REQ-025 Holding a button high SHALL produce exactly one rise pulse regardless of hold time.

Reset
REQ-026 While rst is high at a clk edge: synchronizers, debounced levels, stable counters, rise pulses, prescaler and paused SHALL all be 0; all outputs 0 in the following cycle.
REQ-027 rst mid-count SHALL discard partial stable counts; a button already held at rst release SHALL be accepted after STABLE_COUNT full ticks and produce one rise pulse.
REQ-028 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-029 Default SAMPLE_DIV, STABLE_COUNT and channel index constants (CH_RST, CH_PAUSE, CH_ADJ, CH_SEL) SHALL live in the shared stopwatch package.
REQ-030 One sub-module, db_channel (synchronizer, stable counter, debounced level, rise pulse), SHALL be instantiated four times; prescaler and pause toggle stay in the top.

Verification (SAMPLE_DIV=4, STABLE_COUNT=3)
REQ-031 rst high 3 cycles, inputs 0 -> all outputs 0; sample_tick every 4th clk after release.
REQ-032 pause_button 0->1 held 40 clk -> paused 0->1 once, at 2 sync + 3 ticks + 1 clk; release and press again -> paused returns to 0.
REQ-033 adj_switch pulse 1 lasting 2 ticks then 0 -> adj remains 0; held 3 ticks -> adj 1.
REQ-034 pause_button held for 200 clk -> exactly one toggle; paused stays 1 until next press.
REQ-035 paused=1, press rst_button and pause_button together -> clear pulses exactly 1 clk, paused 0 and stays 0 while rst_button held.
REQ-036 assert rst while sel_switch has 2 of 3 differing samples -> sel 0 after rst; sel_switch still 1 -> sel 1 exactly 3 ticks after release.
